// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART.
//   - parity mode encodings (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - TX and RX FSM state encodings
//   - OVERSAMPLE: tick16 periods per bit
//   - calc_div(): rounded clk-per-tick16 divisor, never below 1
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
   } rx_state_e;

   // round(clk_hz / (baud * OVERSAMPLE)), clamped to at least 1
   function automatic int calc_div(input int clk_hz, input int baud);
      longint d;
      d = (longint'(clk_hz) + longint'(baud) * OVERSAMPLE / 2)
          / (longint'(baud) * OVERSAMPLE);
      if (d < 1) d = 1;
      return int'(d);
   endfunction

endpackage

// File: rtl/uart_core_param_baud_gen.sv
// uart_baud_gen: tick16 divisor counter.
//   clk, rst (sync, active-low), restart (sync: counter back to 0)
//   tick: one-cycle pulse when the counter sits at DIV-1
module uart_baud_gen #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst || restart || cnt == LAST) cnt <= '0;
      else                                cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: parametrised full-duplex UART (CLK_HZ, BAUD, DATA_BITS 5..9,
// STOP_BITS 1/2, PARITY 0 none / 1 odd / 2 even).
//   clk, rst (sync, active-low)
//   tx_valid/tx_data/tx_ready : transmit handshake; TxD serial out (idle high)
//   RxD : async serial in; rx_valid pulse with rx_data, rx_parity_err,
//         rx_frame_err (held until the next frame)
//   rx_idle : line high for 16+ bit times; rx_endofpacket : pulse when
//         rx_idle rises after at least one frame
// Optional macro UART_LOOPBACK_EN adds input loopback: RX listens to the
// internal TX line and the TxD pin is held high.
module uart_core_param
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 TxD,
   input  logic                 RxD,
`ifdef UART_LOOPBACK_EN
   input  logic                 loopback,
`endif
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_idle,
   output logic                 rx_endofpacket
);
   localparam int         DIV       = calc_div(CLK_HZ, BAUD);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic       PAR_INV   = (PARITY == PAR_ODD);

   // ---------------- transmitter ----------------
   tx_state_e            tx_state, tx_state_nxt;
   logic [3:0]           tx_phase, tx_cnt;
   logic [DATA_BITS-1:0] tx_sh;
   logic                 tx_par, txd_r, txd_nxt;
   logic                 tx_tick, tx_accept, tx_bit_done;
   logic                 tx_shift, tx_cnt_clr, tx_cnt_inc;

   assign tx_ready    = (tx_state == TX_IDLE);
   assign tx_accept   = tx_valid && tx_ready;
   assign tx_bit_done = tx_tick && (tx_phase == 4'd15);

   // restart on accept so the start bit is exactly one bit time long
   uart_baud_gen #(.DIV(DIV)) u_tx_baud (
      .clk(clk), .rst(rst), .restart(tx_accept), .tick(tx_tick)
   );

   always_comb begin
      tx_state_nxt = tx_state;
      txd_nxt      = txd_r;
      tx_shift     = 1'b0;
      tx_cnt_clr   = 1'b0;
      tx_cnt_inc   = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            txd_nxt = 1'b1;
            if (tx_valid) begin
               tx_state_nxt = TX_START;
               txd_nxt      = 1'b0;
            end
         end
         TX_START: if (tx_bit_done) begin
            tx_state_nxt = TX_DATA;
            txd_nxt      = tx_sh[0];
            tx_cnt_clr   = 1'b1;
         end
         TX_DATA: if (tx_bit_done) begin
            tx_shift = 1'b1;
            if (tx_cnt == LAST_DATA) begin
               tx_cnt_clr = 1'b1;
               if (PARITY != PAR_NONE) begin
                  tx_state_nxt = TX_PARITY;
                  txd_nxt      = tx_par;
               end else begin
                  tx_state_nxt = TX_STOP;
                  txd_nxt      = 1'b1;
               end
            end else begin
               tx_cnt_inc = 1'b1;
               txd_nxt    = tx_sh[1];   // next bit after this shift
            end
         end
         TX_PARITY: if (tx_bit_done) begin
            tx_state_nxt = TX_STOP;
            txd_nxt      = 1'b1;
            tx_cnt_clr   = 1'b1;
         end
         TX_STOP: if (tx_bit_done) begin
            if (tx_cnt == LAST_STOP) tx_state_nxt = TX_IDLE;
            else                     tx_cnt_inc   = 1'b1;
         end
         default: begin
            tx_state_nxt = TX_IDLE;
            txd_nxt      = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         txd_r    <= 1'b1;
         tx_phase <= '0;
         tx_cnt   <= '0;
         tx_sh    <= '0;
         tx_par   <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt;
         txd_r    <= txd_nxt;
         if (tx_accept) begin
            tx_sh    <= tx_data;
            tx_par   <= (^tx_data) ^ PAR_INV;
            tx_phase <= '0;
            tx_cnt   <= '0;
         end else begin
            if (tx_tick)         tx_phase <= tx_phase + 1'b1;
            if (tx_shift)        tx_sh    <= tx_sh >> 1;
            if (tx_cnt_clr)      tx_cnt   <= '0;
            else if (tx_cnt_inc) tx_cnt   <= tx_cnt + 1'b1;
         end
      end
   end

   // ---------------- line routing ----------------
   logic rx_line;
`ifdef UART_LOOPBACK_EN
   assign rx_line = loopback ? txd_r : RxD;
   assign TxD     = loopback ? 1'b1  : txd_r;
`else
   assign rx_line = RxD;
   assign TxD     = txd_r;
`endif

   // ---------------- receiver ----------------
   rx_state_e            rx_state, rx_state_nxt;
   logic                 sync1, rxs;
   logic [3:0]           rx_phase, rx_cnt;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 perr_acc, ferr_acc, got_frame;
   logic [4:0]           idle_cnt;
   logic                 rx_tick, start_det, mid_smp, bit_smp;
   logic                 rx_shift, rx_cnt_clr, rx_cnt_inc, rx_phase_clr;
   logic                 par_chk, stop_chk, rx_done, eop_fire;

   assign start_det = (rx_state == RX_IDLE) && !rxs;
   assign mid_smp   = rx_tick && (rx_phase == 4'd7);
   assign bit_smp   = rx_tick && (rx_phase == 4'd15);
   assign eop_fire  = !start_det && (idle_cnt == 5'd16) && !rx_idle && got_frame;

   uart_baud_gen #(.DIV(DIV)) u_rx_baud (
      .clk(clk), .rst(rst), .restart(start_det), .tick(rx_tick)
   );

   always_comb begin
      rx_state_nxt = rx_state;
      rx_shift     = 1'b0;
      rx_cnt_clr   = 1'b0;
      rx_cnt_inc   = 1'b0;
      rx_phase_clr = 1'b0;
      par_chk      = 1'b0;
      stop_chk     = 1'b0;
      rx_done      = 1'b0;
      case (rx_state)
         RX_IDLE: if (!rxs) begin
            rx_state_nxt = RX_START;
            rx_phase_clr = 1'b1;
            rx_cnt_clr   = 1'b1;
         end
         // mid-start resample; realign phase so later samples land mid-bit
         RX_START: if (mid_smp) begin
            rx_state_nxt = rxs ? RX_IDLE : RX_DATA;
            rx_phase_clr = 1'b1;
         end
         RX_DATA: if (bit_smp) begin
            rx_shift = 1'b1;
            if (rx_cnt == LAST_DATA) begin
               rx_cnt_clr   = 1'b1;
               rx_state_nxt = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
               rx_cnt_inc = 1'b1;
            end
         end
         RX_PARITY: if (bit_smp) begin
            par_chk      = 1'b1;
            rx_state_nxt = RX_STOP;
         end
         RX_STOP: if (bit_smp) begin
            stop_chk = 1'b1;
            if (rx_cnt == LAST_STOP) begin
               rx_done      = 1'b1;
               rx_phase_clr = 1'b1;
               // a low stop bit may be a break: wait for the line to recover
               rx_state_nxt = (ferr_acc || !rxs) ? RX_WAIT_HIGH : RX_IDLE;
            end else begin
               rx_cnt_inc = 1'b1;
            end
         end
         RX_WAIT_HIGH: if (rxs) rx_state_nxt = RX_IDLE;
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state       <= RX_IDLE;
         sync1          <= 1'b1;
         rxs            <= 1'b1;
         rx_phase       <= '0;
         rx_cnt         <= '0;
         rx_sh          <= '0;
         perr_acc       <= 1'b0;
         ferr_acc       <= 1'b0;
         got_frame      <= 1'b0;
         idle_cnt       <= '0;
         rx_valid       <= 1'b0;
         rx_data        <= '0;
         rx_parity_err  <= 1'b0;
         rx_frame_err   <= 1'b0;
         rx_idle        <= 1'b0;
         rx_endofpacket <= 1'b0;
      end else begin
         rx_state <= rx_state_nxt;
         sync1    <= rx_line;
         rxs      <= sync1;

         if (rx_phase_clr) rx_phase <= '0;
         else if (rx_tick) rx_phase <= rx_phase + 1'b1;

         if (rx_cnt_clr)      rx_cnt <= '0;
         else if (rx_cnt_inc) rx_cnt <= rx_cnt + 1'b1;

         if (rx_shift) rx_sh <= {rxs, rx_sh[DATA_BITS-1:1]};

         if (start_det) begin
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
         end else begin
            if (par_chk)          perr_acc <= (rxs != ((^rx_sh) ^ PAR_INV));
            if (stop_chk && !rxs) ferr_acc <= 1'b1;
         end

         rx_valid <= rx_done;
         if (rx_done) begin
            rx_data       <= rx_sh;
            rx_parity_err <= perr_acc;
            rx_frame_err  <= ferr_acc || !rxs;
         end

         // idle bit-time counter, using the free-running RX phase in IDLE
         if (rx_state != RX_IDLE || !rxs)          idle_cnt <= '0;
         else if (bit_smp && idle_cnt != 5'd16)    idle_cnt <= idle_cnt + 1'b1;

         if (start_det)               rx_idle <= 1'b0;
         else if (idle_cnt == 5'd16)  rx_idle <= 1'b1;

         rx_endofpacket <= eop_fire;
         if (rx_done)       got_frame <= 1'b1;
         else if (eop_fire) got_frame <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench: DUT A defaults (TX waveform, RX error/idle cases, reset),
// DUT B even parity + 2 stop bits looped TxD->RxD, DUT C odd parity.
module tb_uart_core_param;
   localparam int BIT = 432;   // 27 clk per tick16 * 16

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // DUT A: defaults
   logic       rst_a = 1'b0, tx_valid_a = 1'b0, rxd_a = 1'b1;
   logic [7:0] tx_data_a = '0, rx_data_a;
   logic       tx_ready_a, txd_a, rx_valid_a, perr_a, ferr_a, idle_a, eop_a;

   uart_core_param u_a (
      .clk(clk), .rst(rst_a), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
      .tx_ready(tx_ready_a), .TxD(txd_a), .RxD(rxd_a),
`ifdef UART_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_parity_err(perr_a),
      .rx_frame_err(ferr_a), .rx_idle(idle_a), .rx_endofpacket(eop_a)
   );

   // DUT B: even parity, 2 stop bits, TxD wired to RxD
   logic       rst_bc = 1'b0, tx_valid_b = 1'b0;
   logic [7:0] tx_data_b = '0, rx_data_b;
   logic       tx_ready_b, txd_b, rx_valid_b, perr_b, ferr_b, idle_b, eop_b;

   uart_core_param #(.PARITY(2), .STOP_BITS(2)) u_b (
      .clk(clk), .rst(rst_bc), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
      .tx_ready(tx_ready_b), .TxD(txd_b), .RxD(txd_b),
`ifdef UART_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_parity_err(perr_b),
      .rx_frame_err(ferr_b), .rx_idle(idle_b), .rx_endofpacket(eop_b)
   );

   // DUT C: odd parity, RX driven by the bench
   logic       rxd_c = 1'b1;
   logic [7:0] rx_data_c;
   logic       tx_ready_c, txd_c, rx_valid_c, perr_c, ferr_c, idle_c, eop_c;

   uart_core_param #(.PARITY(1)) u_c (
      .clk(clk), .rst(rst_bc), .tx_valid(1'b0), .tx_data(8'h00),
      .tx_ready(tx_ready_c), .TxD(txd_c), .RxD(rxd_c),
`ifdef UART_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .rx_valid(rx_valid_c), .rx_data(rx_data_c), .rx_parity_err(perr_c),
      .rx_frame_err(ferr_c), .rx_idle(idle_c), .rx_endofpacket(eop_c)
   );

   int nv_a = 0, neop_a = 0, nv_b = 0, nv_c = 0;
   always @(negedge clk) begin
      if (rx_valid_a) nv_a++;
      if (eop_a)      neop_a++;
      if (rx_valid_b) nv_b++;
      if (rx_valid_c) nv_c++;
   end

   task automatic line(input int sel, input logic v, input int cyc);
      if (sel == 0) rxd_a = v;
      else          rxd_c = v;
      repeat (cyc) @(negedge clk);
   endtask

   task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) line(sel, bits[i], BIT);
   endtask

   // send d on DUT A, check every bit mid-way and the busy length
   task automatic tx_chk_a(input logic [7:0] d);
      logic [9:0] fb;
      int low;
      fb  = {1'b1, d, 1'b0};
      low = 0;
      @(negedge clk);
      tx_valid_a = 1'b1;
      tx_data_a  = d;
      @(posedge clk);
      #1 tx_valid_a = 1'b0;
      for (int n = 1; n <= 4500; n++) begin
         @(negedge clk);
         if (n % BIT == BIT / 2) chk($sformatf("tx_bit%0d_%0h", n / BIT, d), 32'(txd_a), 32'(fb[n / BIT]));
         if (!tx_ready_a) low++;
      end
      chk("tx_ready_low_len", low, 4320);
   endtask

   initial begin
      int low;
      repeat (3) @(negedge clk);
      // reset values
      chk("rst_txd",      32'(txd_a), 1);
      chk("rst_tx_ready", 32'(tx_ready_a), 1);
      chk("rst_rx_valid", 32'(rx_valid_a), 0);
      chk("rst_rx_data",  32'(rx_data_a), 0);
      chk("rst_perr",     32'(perr_a), 0);
      chk("rst_ferr",     32'(ferr_a), 0);
      chk("rst_idle",     32'(idle_a), 0);
      chk("rst_eop",      32'(eop_a), 0);
      rst_a  = 1'b1;
      rst_bc = 1'b1;

      // TX waveform 0xA5
      tx_chk_a(8'hA5);

      // long idle with no frame yet: rx_idle up, no end-of-packet
      line(0, 1'b1, 20 * BIT);
      chk("idle_after_reset", 32'(idle_a), 1);
      chk("no_eop_without_frame", neop_a, 0);

      // 0x55 with low stop bit, then 3 more low bit times
      send_bits(0, {1'b0, 8'h55, 1'b0}, 10);
      line(0, 1'b0, 3 * BIT);
      line(0, 1'b1, 2 * BIT);
      chk("ferr_count",    nv_a, 1);
      chk("ferr_data",     32'(rx_data_a), 32'h55);
      chk("ferr_flag",     32'(ferr_a), 1);
      chk("ferr_perr",     32'(perr_a), 0);
      chk("idle_cleared",  32'(idle_a), 0);

      // clean 0x12 after the break
      send_bits(0, {1'b1, 8'h12, 1'b0}, 10);
      line(0, 1'b1, BIT);
      chk("after_break_count", nv_a, 2);
      chk("after_break_data",  32'(rx_data_a), 32'h12);
      chk("after_break_ferr",  32'(ferr_a), 0);

      // 100 clk glitch: no frame
      line(0, 1'b0, 100);
      line(0, 1'b1, 2 * BIT);
      chk("glitch_no_valid", nv_a, 2);
      chk("eop_not_yet", neop_a, 0);
      line(0, 1'b1, 18 * BIT);
      chk("eop_once", neop_a, 1);
      chk("idle_set", 32'(idle_a), 1);
      line(0, 1'b1, 5 * BIT);
      chk("eop_still_once", neop_a, 1);

      // reset in the middle of a data bit
      @(negedge clk);
      tx_valid_a = 1'b1;
      tx_data_a  = 8'h00;
      @(posedge clk);
      #1 tx_valid_a = 1'b0;
      repeat (2 * BIT + 100) @(negedge clk);
      chk("pre_rst_txd_low", 32'(txd_a), 0);
      rst_a = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_txd",   32'(txd_a), 1);
      chk("mid_rst_ready", 32'(tx_ready_a), 1);
      rst_a = 1'b1;
      tx_chk_a(8'hFF);

      // DUT B loopback 0x3C, even parity, 2 stop bits
      @(negedge clk);
      tx_valid_b = 1'b1;
      tx_data_b  = 8'h3C;
      @(posedge clk);
      #1 tx_valid_b = 1'b0;
      low = 0;
      for (int n = 1; n <= 5600; n++) begin
         @(negedge clk);
         if (!tx_ready_b) low++;
      end
      chk("b_frame_len", low, 12 * BIT);
      chk("b_count", nv_b, 1);
      chk("b_data",  32'(rx_data_b), 32'h3C);
      chk("b_perr",  32'(perr_b), 0);
      chk("b_ferr",  32'(ferr_b), 0);

      // DUT C odd parity: 0x01 with wrong parity 1, then 0x03 with correct parity 1
      send_bits(1, {1'b1, 1'b1, 8'h01, 1'b0}, 11);
      line(1, 1'b1, BIT);
      chk("c_bad_count", nv_c, 1);
      chk("c_bad_data",  32'(rx_data_c), 32'h01);
      chk("c_bad_perr",  32'(perr_c), 1);
      chk("c_bad_ferr",  32'(ferr_c), 0);
      send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
      line(1, 1'b1, BIT);
      chk("c_good_count", nv_c, 2);
      chk("c_good_data",  32'(rx_data_c), 32'h03);
      chk("c_good_perr",  32'(perr_c), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
